// File: rtl/alu_sequencer.sv
// alu_sequencer: micro-sequencer for an external 4-bit ALU.
// It accepts one command at a time, drives the ALU operands and function
// select, and writes results back into an accumulator with carry and zero
// flags. MUL is a repeated-add loop that runs cmd_data+1 cycles.
module alu_sequencer (
   input  logic       clk,
   input  logic       reset,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [2:0] cmd_op,
   input  logic [3:0] cmd_data,
   output logic [3:0] alu_a,
   output logic [3:0] alu_b,
   output logic [2:0] alu_f,
   input  logic [3:0] alu_s,
   input  logic       alu_c,
   input  logic       alu_z,
   output logic [3:0] acc,
   output logic       c_flag,
   output logic       z_flag,
   output logic [3:0] out_data,
   output logic       out_valid,
   output logic       done
);

   // Command opcodes
   localparam logic [2:0] OP_NOP  = 3'b000;
   localparam logic [2:0] OP_LD   = 3'b001;
   localparam logic [2:0] OP_ADD  = 3'b010;
   localparam logic [2:0] OP_CMP  = 3'b011;
   localparam logic [2:0] OP_NAND = 3'b100;
   localparam logic [2:0] OP_OUT  = 3'b101;
   localparam logic [2:0] OP_MUL  = 3'b110;

   // ALU function selects
   localparam logic [2:0] F_PASS_A = 3'b000;
   localparam logic [2:0] F_SUB    = 3'b001;
   localparam logic [2:0] F_PASS_B = 3'b010;
   localparam logic [2:0] F_ADD    = 3'b011;
   localparam logic [2:0] F_NAND   = 3'b100;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_EXEC = 2'b01,
      ST_MUL  = 2'b10,
      ST_DONE = 2'b11
   } state_t;

   state_t     r_state;
   logic [2:0] r_op;
   logic [3:0] r_data;
   logic [3:0] r_acc;
   logic       r_c;
   logic       r_z;
   logic [3:0] r_out_data;
   logic       r_out_valid;
   logic       r_done;
   logic       r_cmd_ready;
   logic [3:0] r_p;
   logic [3:0] r_m;
   logic [3:0] r_n;
   logic       r_k;

   logic [3:0] w_alu_a;
   logic [3:0] w_alu_b;
   logic [2:0] w_alu_f;
   logic       w_accept;

   // Map a single-cycle opcode onto the ALU function it needs
   function automatic logic [2:0] op_to_func(input logic [2:0] op);
      logic [2:0] f;
      case (op)
         OP_LD:   f = F_PASS_B;
         OP_ADD:  f = F_ADD;
         OP_CMP:  f = F_SUB;
         OP_NAND: f = F_NAND;
         OP_OUT:  f = F_PASS_A;
         default: f = F_PASS_A;
      endcase
      return f;
   endfunction

   assign w_accept = cmd_valid && r_cmd_ready;

   // ALU operand/function decode from the current state (idle value: acc, 0, pass A)
   always_comb begin
      w_alu_a = r_acc;
      w_alu_b = 4'd0;
      w_alu_f = F_PASS_A;
      case (r_state)
         ST_EXEC: begin
            w_alu_a = r_acc;
            w_alu_b = r_data;
            w_alu_f = op_to_func(r_op);
         end
         ST_MUL: begin
            if (r_n != 4'd0) begin
               w_alu_a = r_p;
               w_alu_b = r_m;
               w_alu_f = F_ADD;
            end else begin
               w_alu_a = r_acc;
               w_alu_b = 4'd0;
               w_alu_f = F_PASS_A;
            end
         end
         default: begin
            w_alu_a = r_acc;
            w_alu_b = 4'd0;
            w_alu_f = F_PASS_A;
         end
      endcase
   end

   // Sequencer FSM: command accept, execution, multiply loop and result write-back
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_op        <= 3'd0;
         r_data      <= 4'd0;
         r_acc       <= 4'd0;
         r_c         <= 1'b0;
         r_z         <= 1'b0;
         r_out_data  <= 4'd0;
         r_out_valid <= 1'b0;
         r_done      <= 1'b0;
         r_cmd_ready <= 1'b1;
         r_p         <= 4'd0;
         r_m         <= 4'd0;
         r_n         <= 4'd0;
         r_k         <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_done      <= 1'b0;
               r_out_valid <= 1'b0;
               if (w_accept) begin
                  r_op        <= cmd_op;
                  r_data      <= cmd_data;
                  r_cmd_ready <= 1'b0;
                  if (cmd_op == OP_MUL) begin
                     r_p     <= 4'd0;
                     r_m     <= r_acc;
                     r_n     <= cmd_data;
                     r_k     <= 1'b0;
                     r_state <= ST_MUL;
                  end else begin
                     r_state <= ST_EXEC;
                  end
               end else begin
                  r_cmd_ready <= 1'b1;
               end
            end
            ST_EXEC: begin
               case (r_op)
                  OP_LD: begin
                     r_acc <= alu_s;
                     r_z   <= alu_z;
                  end
                  OP_ADD: begin
                     r_acc <= alu_s;
                     r_c   <= alu_c;
                     r_z   <= alu_z;
                  end
                  OP_CMP: begin
                     r_c <= alu_c;
                     r_z <= alu_z;
                  end
                  OP_NAND: begin
                     r_acc <= alu_s;
                     r_z   <= alu_z;
                  end
                  OP_OUT: begin
                     r_out_data  <= alu_s;
                     r_out_valid <= 1'b1;
                  end
                  default: begin
                     r_acc <= r_acc;
                  end
               endcase
               r_done  <= 1'b1;
               r_state <= ST_DONE;
            end
            ST_MUL: begin
               if (r_n != 4'd0) begin
                  r_p <= alu_s;
                  r_k <= r_k | alu_c;
                  r_n <= r_n - 4'd1;
               end else begin
                  r_acc   <= r_p;
                  r_c     <= r_k;
                  r_z     <= (r_p == 4'd0);
                  r_done  <= 1'b1;
                  r_state <= ST_DONE;
               end
            end
            ST_DONE: begin
               r_done      <= 1'b0;
               r_out_valid <= 1'b0;
               r_cmd_ready <= 1'b1;
               r_state     <= ST_IDLE;
            end
            default: begin
               r_done      <= 1'b0;
               r_out_valid <= 1'b0;
               r_cmd_ready <= 1'b1;
               r_state     <= ST_IDLE;
            end
         endcase
      end
   end

   assign cmd_ready = r_cmd_ready;
   assign alu_a     = w_alu_a;
   assign alu_b     = w_alu_b;
   assign alu_f     = w_alu_f;
   assign acc       = r_acc;
   assign c_flag    = r_c;
   assign z_flag    = r_z;
   assign out_data  = r_out_data;
   assign out_valid = r_out_valid;
   assign done      = r_done;

endmodule

// File: tb/tb_alu_sequencer.sv
// Testbench for alu_sequencer: a behavioural 4-bit ALU closes the loop, and a
// command-level reference model predicts accumulator, flags, output and latency.
module tb_alu_sequencer;

   logic       clk;
   logic       reset;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [2:0] cmd_op;
   logic [3:0] cmd_data;
   logic [3:0] alu_a;
   logic [3:0] alu_b;
   logic [2:0] alu_f;
   logic [3:0] alu_s;
   logic       alu_c;
   logic       alu_z;
   logic [3:0] acc;
   logic       c_flag;
   logic       z_flag;
   logic [3:0] out_data;
   logic       out_valid;
   logic       done;

   logic [4:0] alu_ext;

   int n_cmp;
   int n_err;

   // reference model state
   logic [3:0] m_acc;
   logic       m_c;
   logic       m_z;
   logic [3:0] m_out;
   int         exp_lat;
   logic       exp_ov;

   alu_sequencer dut (
      .clk       (clk),
      .reset     (reset),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_data  (cmd_data),
      .alu_a     (alu_a),
      .alu_b     (alu_b),
      .alu_f     (alu_f),
      .alu_s     (alu_s),
      .alu_c     (alu_c),
      .alu_z     (alu_z),
      .acc       (acc),
      .c_flag    (c_flag),
      .z_flag    (z_flag),
      .out_data  (out_data),
      .out_valid (out_valid),
      .done      (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // external ALU: 5-bit result, bit 4 is carry (add) or borrow (sub)
   always_comb begin
      alu_ext = 5'd0;
      case (alu_f)
         3'b000:  alu_ext = {1'b0, alu_a};
         3'b001:  alu_ext = {1'b0, alu_a} - {1'b0, alu_b};
         3'b010:  alu_ext = {1'b0, alu_b};
         3'b011:  alu_ext = {1'b0, alu_a} + {1'b0, alu_b};
         3'b100:  alu_ext = {1'b0, ~(alu_a & alu_b)};
         default: alu_ext = 5'd0;
      endcase
   end
   assign alu_s = alu_ext[3:0];
   assign alu_c = alu_ext[4];
   assign alu_z = (alu_ext[3:0] == 4'd0);

   // command-level model: whole-result arithmetic, no cycle detail
   task automatic model_cmd(input int op, input int d);
      int t;
      exp_lat = 2;
      exp_ov  = 1'b0;
      case (op)
         1: begin m_acc = 4'(d); m_z = (d == 0); end
         2: begin t = int'(m_acc) + d; m_c = (t > 15); m_acc = 4'(t % 16); m_z = (t % 16 == 0); end
         3: begin m_c = (int'(m_acc) < d); m_z = (int'(m_acc) == d); end
         4: begin t = 15 - (int'(m_acc) & d); m_acc = 4'(t); m_z = (t == 0); end
         5: begin m_out = m_acc; exp_ov = 1'b1; end
         6: begin t = int'(m_acc) * d; m_c = (t > 15); m_acc = 4'(t % 16); m_z = (t % 16 == 0); exp_lat = d + 2; end
         default: begin t = 0; end
      endcase
   endtask

   // issue one command and check latency, result and return to idle;
   // with hold=1, cmd_valid stays high (carrying LD 7) while the sequencer is busy
   task automatic run_cmd(input logic [2:0] op, input logic [3:0] data, input bit hold);
      int  lat;
      int  wait_n;
      bit  seen;
      wait_n = 0;
      while (cmd_ready !== 1'b1 && wait_n < 40) begin
         @(negedge clk);
         wait_n++;
      end
      n_cmp++;
      if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL ready_wait: cmd_ready=%b required 1", cmd_ready); end
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_data  = data;
      @(posedge clk);
      @(negedge clk);
      if (hold) begin
         cmd_op   = 3'b001;
         cmd_data = 4'd7;
      end else begin
         cmd_valid = 1'b0;
      end
      model_cmd(int'(op), int'(data));
      lat  = 1;
      seen = 1'b0;
      while (!seen && lat <= 40) begin
         n_cmp++;
         if (cmd_ready !== 1'b0) begin n_err++; $display("FAIL busy_ready op=%0d cycle=%0d: cmd_ready=%b required 0", op, lat, cmd_ready); end
         if (done === 1'b1) seen = 1'b1;
         else begin
            @(negedge clk);
            lat++;
         end
      end
      n_cmp++;
      if (!seen || lat != exp_lat) begin n_err++; $display("FAIL latency op=%0d data=%0d: got %0d (seen=%0d) required %0d", op, data, lat, seen, exp_lat); end
      n_cmp++;
      if (out_valid !== exp_ov) begin n_err++; $display("FAIL out_valid op=%0d: got %b required %b", op, out_valid, exp_ov); end
      n_cmp++;
      if (acc !== m_acc) begin n_err++; $display("FAIL acc op=%0d data=%0d: got %h required %h", op, data, acc, m_acc); end
      n_cmp++;
      if (c_flag !== m_c) begin n_err++; $display("FAIL c_flag op=%0d data=%0d: got %b required %b", op, data, c_flag, m_c); end
      n_cmp++;
      if (z_flag !== m_z) begin n_err++; $display("FAIL z_flag op=%0d data=%0d: got %b required %b", op, data, z_flag, m_z); end
      n_cmp++;
      if (out_data !== m_out) begin n_err++; $display("FAIL out_data op=%0d: got %h required %h", op, out_data, m_out); end
      @(negedge clk);
      n_cmp++;
      if (done !== 1'b0) begin n_err++; $display("FAIL done_width op=%0d: done=%b required 0", op, done); end
      n_cmp++;
      if (out_valid !== 1'b0) begin n_err++; $display("FAIL ov_width op=%0d: out_valid=%b required 0", op, out_valid); end
      n_cmp++;
      if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL idle_ready op=%0d: cmd_ready=%b required 1", op, cmd_ready); end
      n_cmp++;
      if (alu_a !== m_acc || alu_b !== 4'd0 || alu_f !== 3'b000) begin
         n_err++;
         $display("FAIL idle_alu: a=%h b=%h f=%b required a=%h b=0 f=000", alu_a, alu_b, alu_f, m_acc);
      end
   endtask

   task automatic test_reset();
      reset     = 1'b1;
      cmd_valid = 1'b0;
      cmd_op    = 3'd0;
      cmd_data  = 4'd0;
      m_acc = 4'd0; m_c = 1'b0; m_z = 1'b0; m_out = 4'd0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      n_cmp++;
      if (acc !== 4'd0 || c_flag !== 1'b0 || z_flag !== 1'b0 || out_data !== 4'd0) begin
         n_err++;
         $display("FAIL reset_regs: acc=%h c=%b z=%b out=%h required 0", acc, c_flag, z_flag, out_data);
      end
      n_cmp++;
      if (done !== 1'b0 || out_valid !== 1'b0 || cmd_ready !== 1'b1) begin
         n_err++;
         $display("FAIL reset_ctrl: done=%b ov=%b ready=%b required 0 0 1", done, out_valid, cmd_ready);
      end
      n_cmp++;
      if (alu_b !== 4'd0 || alu_f !== 3'b000) begin n_err++; $display("FAIL reset_alu: b=%h f=%b required 0 000", alu_b, alu_f); end
   endtask

   task automatic test_ld_add();
      run_cmd(3'b001, 4'b1111, 1'b0);
      run_cmd(3'b010, 4'b0001, 1'b0);
      n_cmp++;
      if (acc !== 4'b0000 || c_flag !== 1'b1 || z_flag !== 1'b1) begin
         n_err++;
         $display("FAIL ld_add: acc=%b c=%b z=%b required 0000 1 1", acc, c_flag, z_flag);
      end
   endtask

   task automatic test_cmp();
      run_cmd(3'b001, 4'b0101, 1'b0);
      run_cmd(3'b011, 4'b0101, 1'b0);
      run_cmd(3'b011, 4'b0110, 1'b0);
      run_cmd(3'b011, 4'b0011, 1'b0);
      n_cmp++;
      if (acc !== 4'b0101 || c_flag !== 1'b0 || z_flag !== 1'b0) begin
         n_err++;
         $display("FAIL cmp_last: acc=%b c=%b z=%b required 0101 0 0", acc, c_flag, z_flag);
      end
   endtask

   task automatic test_mul();
      run_cmd(3'b001, 4'b0011, 1'b0);
      run_cmd(3'b110, 4'b0101, 1'b0);
      n_cmp++;
      if (acc !== 4'b1111 || c_flag !== 1'b0 || z_flag !== 1'b0) begin
         n_err++;
         $display("FAIL mul_3x5: acc=%b c=%b z=%b required 1111 0 0", acc, c_flag, z_flag);
      end
      run_cmd(3'b001, 4'b0100, 1'b0);
      run_cmd(3'b110, 4'b0100, 1'b0);
      run_cmd(3'b110, 4'b0000, 1'b0);
      n_cmp++;
      if (acc !== 4'b0000 || c_flag !== 1'b0 || z_flag !== 1'b1) begin
         n_err++;
         $display("FAIL mul_by0: acc=%b c=%b z=%b required 0000 0 1", acc, c_flag, z_flag);
      end
   endtask

   task automatic test_nand_out();
      run_cmd(3'b010, 4'b0001, 1'b0);
      run_cmd(3'b001, 4'b1010, 1'b0);
      run_cmd(3'b100, 4'b0110, 1'b0);
      run_cmd(3'b101, 4'b0000, 1'b0);
      n_cmp++;
      if (out_data !== 4'b1101 || acc !== 4'b1101 || z_flag !== 1'b0) begin
         n_err++;
         $display("FAIL nand_out: out=%b acc=%b z=%b required 1101 1101 0", out_data, acc, z_flag);
      end
   endtask

   task automatic test_ignore_busy();
      run_cmd(3'b001, 4'd2, 1'b1);
      run_cmd(3'b001, 4'd7, 1'b0);
      run_cmd(3'b110, 4'd3, 1'b1);
      run_cmd(3'b001, 4'd7, 1'b0);
      run_cmd(3'b011, 4'd9, 1'b1);
      run_cmd(3'b001, 4'd7, 1'b0);
   endtask

   task automatic test_random();
      logic [2:0] op;
      logic [3:0] d;
      for (int i = 0; i < 40; i++) begin
         op = 3'($urandom_range(0, 7));
         d  = 4'($urandom_range(0, 15));
         run_cmd(op, d, 1'b0);
      end
   endtask

   task automatic test_reset_mid_mul();
      bit seen_done;
      run_cmd(3'b001, 4'd3, 1'b0);
      run_cmd(3'b101, 4'd0, 1'b0);
      cmd_valid = 1'b1;
      cmd_op    = 3'b110;
      cmd_data  = 4'd15;
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      repeat (4) @(negedge clk);
      #3;
      reset = 1'b1;
      #1;
      m_acc = 4'd0; m_c = 1'b0; m_z = 1'b0; m_out = 4'd0;
      n_cmp++;
      if (acc !== 4'd0 || c_flag !== 1'b0 || z_flag !== 1'b0 || out_data !== 4'd0) begin
         n_err++;
         $display("FAIL async_reset_regs: acc=%h c=%b z=%b out=%h required 0", acc, c_flag, z_flag, out_data);
      end
      n_cmp++;
      if (done !== 1'b0 || out_valid !== 1'b0 || cmd_ready !== 1'b1) begin
         n_err++;
         $display("FAIL async_reset_ctrl: done=%b ov=%b ready=%b required 0 0 1", done, out_valid, cmd_ready);
      end
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      seen_done = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (done === 1'b1) seen_done = 1'b1;
      end
      n_cmp++;
      if (seen_done) begin n_err++; $display("FAIL aborted_done: done pulsed=1 required 0"); end
      run_cmd(3'b001, 4'd9, 1'b0);
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      test_reset();
      test_ld_add();
      test_cmp();
      test_mul();
      test_nand_out();
      test_ignore_busy();
      test_random();
      test_reset_mid_mul();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameters: none; all widths fixed (4-bit data, 3-bit ALU function).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 cmd_valid  input  1  command present.
REQ-005 cmd_ready  output  1  sequencer can accept a command.
REQ-006 cmd_op  input  3  command opcode (REQ-012).
REQ-007 cmd_data  input  4  command operand.
REQ-008 alu_a, alu_b  output  4 each  ALU operand A and operand B.
REQ-009 alu_f  output  3  ALU function select (000 pass A, 001 A-B, 010 pass B, 011 A+B, 100 NAND).
REQ-010 alu_s  input  4; alu_c, alu_z  input  1 each  ALU result, carry/borrow, zero.
REQ-011 acc  output  4  accumulator; c_flag, z_flag  output  1 each; out_data  output  4; out_valid  output  1; done  output  1.

Function
REQ-012 Opcodes: 000 NOP; 001 LD (F=010); 010 ADD (F=011); 011 CMP (F=001); 100 NAND (F=100); 101 OUT (F=000); 110 MUL; 111 reserved, executes as NOP.
REQ-013 States: IDLE, EXEC, MUL, DONE; cmd_ready=1 only in IDLE.
REQ-014 Accept when cmd_valid&&cmd_ready at a rising edge: latch cmd_op/cmd_data; next state MUL if op=110, else EXEC.
REQ-015 cmd_valid outside IDLE is ignored; no queuing.
REQ-016 EXEC (one cycle): alu_a=acc, alu_b=latched data, alu_f per REQ-012; at the closing edge apply REQ-017..021; next state DONE.
REQ-017 LD: acc<=alu_s, z_flag<=alu_z, c_flag unchanged.
REQ-018 ADD: acc<=alu_s, c_flag<=alu_c, z_flag<=alu_z (4-bit wrap, carry out in c_flag).
REQ-019 CMP: acc unchanged, c_flag<=alu_c (borrow, 1 when acc<data unsigned), z_flag<=alu_z.
REQ-020 NAND: acc<=alu_s, z_flag<=alu_z, c_flag unchanged.
REQ-021 OUT: out_data<=alu_s (=acc), flags/acc unchanged; out_valid high for exactly the DONE cycle. NOP/111: nothing changes.
REQ-022 MUL on entry: product P<=0, multiplicand M<=acc, count N<=cmd_data, sticky carry K<=0.
REQ-023 MUL with N!=0: alu_a=P, alu_b=M, alu_f=011; at edge P<=alu_s, K<=K|alu_c, N<=N-1.
REQ-024 MUL with N=0: at edge acc<=P, c_flag<=K, z_flag<=(P==0); next state DONE; MUL occupies cmd_data+1 cycles.
REQ-025 DONE: done=1 for one cycle, cmd_ready=0; next state IDLE.
REQ-026 Single-op latency: accept edge -> EXEC cycle -> DONE cycle; next accept no earlier than 3 cycles after previous.
REQ-027 Outside EXEC/MUL: alu_a=acc, alu_b=0000, alu_f=000.
REQ-028 acc, c_flag, z_flag, out_data are registers, held between commands.

Reset
REQ-029 reset=1 forces immediately, independent of clk: state IDLE, acc=0000, c_flag=0, z_flag=0, out_data=0000, out_valid=0, done=0, P/M/N/K=0.
REQ-030 Reset mid-command (EXEC/MUL/DONE) aborts it; no partial write survives; first accept possible on first rising edge with reset=0.

Verification
REQ-031 LD 1111 then ADD 0001 -> acc=0000, c_flag=1, z_flag=1; done pulses 2 cycles after each accept.
REQ-032 acc=0101, CMP 0101 -> z=1,c=0, acc=0101; CMP 0110 -> z=0,c=1; CMP 0011 -> z=0,c=0.
REQ-033 acc=0011, MUL 0101 -> acc=1111, c=0, z=0 after 6 MUL cycles; acc=0100, MUL 0100 -> acc=0000, c=1, z=1; MUL 0000 -> acc=0000, c=0, z=1 after 1 MUL cycle.
REQ-034 acc=1010, NAND 0110 -> acc=1101, z=0, c unchanged; OUT -> out_data=1101, out_valid=1 one cycle.
REQ-035 cmd_valid held high with new op during EXEC/MUL/DONE -> ignored, cmd_ready=0 there; accepted only on return to IDLE.
REQ-036 reset asserted mid-MUL (asynchronous to clk) -> acc=0000, flags 0, state IDLE, done never pulses for aborted command.
